branch_control: RTL and testbench
=================================

# branch_control

Branch decision unit for the RISC-V core's execute stage. It takes the decoder's one-hot branch class, the two register operands and `func3`, and decides whether control flow is redirected. It reports the redirect kind both combinationally and as a registered copy for the fetch/PC-select logic. An optional statistics block counts branch activity.

## Interface
Parameters:
- `XLEN`, default 32: operand width.

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `BranchControl`  in  4  one-hot class from the decoder:
  - 0001: conditional B-type.
  - 0010: JAL.
  - 0100: JALR.
  - 1000: trap return / CSR redirect.
  - 0000: not a control-flow instruction.
- `data1`  in  XLEN  rs1 operand.
- `data2`  in  XLEN  rs2 operand.
- `func3`  in  3  B-type condition select.
- `branch_type`  out  4  one-hot taken kind; equals `BranchControl` when taken, else 0000. Combinational.
- `is_branch`  out  1  redirect taken; equals the OR of `branch_type`. Combinational.
- `branch_type_q`  out  4  `branch_type` registered on `clk`.
- `is_branch_q`  out  1  `is_branch` registered on `clk`.
- `illegal`  out  1  combinational; set for a non-one-hot nonzero `BranchControl`, or for class 0001 with `func3` 010/011.

## Operation
- Conditional class (0001) decodes `func3`:
  - 000 BEQ: `data1 == data2`.
  - 001 BNE: `data1 != data2`.
  - 100 BLT: signed `data1 < data2`.
  - 101 BGE: signed `data1 >= data2`.
  - 110 BLTU: unsigned `data1 < data2`.
  - 111 BGEU: unsigned `data1 >= data2`.
  - 010/011: not taken, `illegal`=1.
- Classes 0010, 0100, 1000 are always taken. Operands and `func3` are ignored.
- Class 0000: `branch_type`=0000, `is_branch`=0, `illegal`=0.
- Any value with more than one bit set: not taken, `branch_type`=0000, `illegal`=1.
- Signed comparisons use full XLEN two's complement. No overflow cases exist, since each comparison is a single compare.
- The unit decides only. Target addresses are computed elsewhere.

## Timing
- `branch_type`, `is_branch` and `illegal` are purely combinational from the inputs, with zero-cycle latency. They must settle within one cycle.
- `branch_type_q` and `is_branch_q` update on every rising edge of `clk`. Latency is 1 cycle and there is no enable.
- Asynchronous reset (`rst_n`=0):
  - `branch_type_q`=0000 and `is_branch_q`=0 immediately, held while reset is low.
  - Registers resume on the first rising edge after release.
  - Combinational outputs are unaffected by reset.
- Reset asserted mid-operation discards the pending registered decision. No redirect is ever emitted out of reset.

## Configuration
- `BRANCH_CTRL_STATS_EN` defined: adds two output ports.
  - `taken_cnt` (32): increments each cycle `is_branch`=1.
  - `cond_cnt` (32): increments each cycle `BranchControl`=0001.
  - Both are asynchronously reset to 0 and wrap from 0xFFFFFFFF to 0.
- Not defined: ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package holds the one-hot class constants (`BR_COND`, `BR_JAL`, `BR_JALR`, `BR_TRAP`) and the `func3` encodings (`F3_BEQ` through `F3_BGEU`), shared with the decoder.
- One sub-module, `branch_cmp`, is natural. It is pure combinational: `data1`, `data2`, `func3` in; `cond_true` and `func3_illegal` out.
- The top level holds the class decode, the output registers and the optional counters.

## Test plan
- `BranchControl`=0001, `data1`=1, `data2`=1, `func3`=000 -> `is_branch`=1, `branch_type`=0001; one cycle later `is_branch_q`=1.
- `data2`=2, `data1`=1, class 0001, stepping `func3` through the conditions:
  - 000 -> 0, 001 -> 1, 100 -> 1, 101 -> 0, 110 -> 1, 111 -> 0 for `is_branch`.
- `data1`=0xFFFFFFFF, `data2`=1, class 0001:
  - `func3`=100 -> taken.
  - `func3`=110 -> not taken.
- With `data1`≠`data2`, class 0010/0100/1000 -> `is_branch`=1 and `branch_type` equal to the class. Class 0000 -> 0000, `is_branch`=0.
- `BranchControl`=0011, or class 0001 with `func3`=010 -> `illegal`=1, `is_branch`=0.
- Taken branch registered, then `rst_n` pulled low between edges -> `is_branch_q`=0 immediately. With `BRANCH_CTRL_STATS_EN`, both counters read 0.

Source files
------------

// File: rtl/branch_control_pkg.sv
// Shared branch-class and func3 encodings for the decoder and branch_control.
package branch_control_pkg;

  localparam logic [3:0] BR_NONE = 4'b0000;
  localparam logic [3:0] BR_COND = 4'b0001;
  localparam logic [3:0] BR_JAL  = 4'b0010;
  localparam logic [3:0] BR_JALR = 4'b0100;
  localparam logic [3:0] BR_TRAP = 4'b1000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic taken;
    logic illegal;
  } br_dec_t;

  // True when more than one class bit is set.
  function automatic logic is_multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/branch_control_if.sv
// Decoder/execute bundle for branch_control; master drives the operands.
interface branch_control_if #(parameter int XLEN = 32);
  logic [3:0]      BranchControl;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [2:0]      func3;
  logic [3:0]      branch_type;
  logic            is_branch;
  logic [3:0]      branch_type_q;
  logic            is_branch_q;
  logic            illegal;

  modport master (
    output BranchControl, data1, data2, func3,
    input  branch_type, is_branch, branch_type_q, is_branch_q, illegal
  );

  modport slave (
    input  BranchControl, data1, data2, func3,
    output branch_type, is_branch, branch_type_q, is_branch_q, illegal
  );
endinterface

// File: rtl/branch_control_cmp.sv
// branch_cmp: combinational B-type condition evaluation from func3.
module branch_cmp
  import branch_control_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      func3,
  output logic            cond_true,
  output logic            func3_illegal
);

  logic signed [XLEN-1:0] w_data1_s;
  logic signed [XLEN-1:0] w_data2_s;

  assign w_data1_s = data1;
  assign w_data2_s = data2;

  always_comb begin
    cond_true     = 1'b0;
    func3_illegal = 1'b0;
    case (func3)
      F3_BEQ:  cond_true = (data1 == data2);
      F3_BNE:  cond_true = (data1 != data2);
      F3_BLT:  cond_true = (w_data1_s <  w_data2_s);
      F3_BGE:  cond_true = (w_data1_s >= w_data2_s);
      F3_BLTU: cond_true = (data1 <  data2);
      F3_BGEU: cond_true = (data1 >= data2);
      default: func3_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_control.sv
// Branch decision unit: class decode, registered redirect copy.
// Optional activity counters enabled by defining BRANCH_CTRL_STATS_EN.
module branch_control
  import branch_control_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_control_if.slave   bus
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]       taken_cnt,
  output logic [31:0]       cond_cnt
`endif
);

  logic    w_cond_true;
  logic    w_f3_illegal;
  br_dec_t w_dec;
  logic [3:0] w_branch_type;

  logic [3:0] r_branch_type_p1;
  logic       r_is_branch_p1;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .data1         (bus.data1),
    .data2         (bus.data2),
    .func3         (bus.func3),
    .cond_true     (w_cond_true),
    .func3_illegal (w_f3_illegal)
  );

  always_comb begin
    w_dec = '0;
    case (bus.BranchControl)
      BR_NONE: w_dec = '0;
      BR_COND: begin
        w_dec.taken   = w_cond_true;
        w_dec.illegal = w_f3_illegal;
      end
      BR_JAL, BR_JALR, BR_TRAP: w_dec.taken = 1'b1;
      default: w_dec.illegal = is_multi_hot(bus.BranchControl);
    endcase
  end

  assign w_branch_type   = w_dec.taken ? bus.BranchControl : BR_NONE;
  assign bus.branch_type = w_branch_type;
  assign bus.is_branch   = |w_branch_type;
  assign bus.illegal     = w_dec.illegal;

  // Stage p0 -> p1: registered copy for PC select; reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_type_p1 <= BR_NONE;
      r_is_branch_p1   <= 1'b0;
    end else begin
      r_branch_type_p1 <= w_branch_type;
      r_is_branch_p1   <= |w_branch_type;
    end
  end

  assign bus.branch_type_q = r_branch_type_p1;
  assign bus.is_branch_q   = r_is_branch_p1;

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] r_taken_cnt;
  logic [31:0] r_cond_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_cond_cnt  <= '0;
    end else begin
      if (|w_branch_type)              r_taken_cnt <= r_taken_cnt + 32'd1;
      if (bus.BranchControl == BR_COND) r_cond_cnt  <= r_cond_cnt + 32'd1;
    end
  end

  assign taken_cnt = r_taken_cnt;
  assign cond_cnt  = r_cond_cnt;
`endif

endmodule

// File: tb/tb_branch_control.sv
// Scoreboard bench for branch_control: directed and random class/operand/func3 mixes.
module tb_branch_control;

  localparam int XLEN = 32;

  typedef struct {
    logic [3:0] bt;
    logic       isb;
    logic       ill;
    int         due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  exp_t q_comb[$];
  exp_t q_reg[$];

  branch_control_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] cond_cnt;
`endif

  branch_control #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .taken_cnt (taken_cnt),
    .cond_cnt  (cond_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decision straight from the branch rules, using wide integer compares.
  function automatic exp_t model(input logic [3:0] bc, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [2:0] f3);
    exp_t   e;
    longint s1, s2, u1, u2;
    bit     take;
    s1 = longint'($signed(d1));
    s2 = longint'($signed(d2));
    u1 = longint'({32'd0, d1});
    u2 = longint'({32'd0, d2});
    take = 0;
    e.ill = 0;
    if ($countones(bc) > 1) e.ill = 1;
    else if (bc == 4'b0001) begin
      case (f3)
        3'd0: take = (u1 == u2);
        3'd1: take = (u1 != u2);
        3'd4: take = (s1 < s2);
        3'd5: take = (s1 >= s2);
        3'd6: take = (u1 < u2);
        3'd7: take = (u1 >= u2);
        default: e.ill = 1;
      endcase
    end else if (bc != 0) take = 1;
    e.bt  = take ? bc : 4'b0000;
    e.isb = take;
    e.due = 0;
    return e;
  endfunction

  task automatic drive(input logic [3:0] bc, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [2:0] f3);
    exp_t e;
    @(posedge clk);
    #1;
    bus.BranchControl = bc;
    bus.data1 = d1;
    bus.data2 = d2;
    bus.func3 = f3;
    e = model(bc, d1, d2, f3);
    e.due = cyc + 1;
    q_comb.push_back(e);
    q_reg.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      chk("branch_type", 32'(bus.branch_type), 32'(e.bt));
      chk("is_branch",   32'(bus.is_branch),   32'(e.isb));
      chk("illegal",     32'(bus.illegal),     32'(e.ill));
    end
    while (q_reg.size() > 0 && q_reg[0].due <= cyc) begin
      e = q_reg.pop_front();
      chk("branch_type_q", 32'(bus.branch_type_q), 32'(e.bt));
      chk("is_branch_q",   32'(bus.is_branch_q),   32'(e.isb));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  bc;
    logic [31:0] d1, d2;
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.BranchControl = 4'b0000;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.func3 = 3'b000;

    #3;
    chk("reset_is_branch_q",   32'(bus.is_branch_q),   32'd0);
    chk("reset_branch_type_q", 32'(bus.branch_type_q), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(4'b0001, 32'd1, 32'd1, 3'b000);
    for (int f = 0; f < 8; f++)
      drive(4'b0001, 32'd1, 32'd2, 3'(f));
    drive(4'b0001, 32'hFFFF_FFFF, 32'd1, 3'b100);
    drive(4'b0001, 32'hFFFF_FFFF, 32'd1, 3'b110);
    drive(4'b0001, 32'h8000_0000, 32'h7FFF_FFFF, 3'b101);
    drive(4'b0001, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111);
    drive(4'b0010, 32'd5, 32'd9, 3'b011);
    drive(4'b0100, 32'd5, 32'd9, 3'b010);
    drive(4'b1000, 32'd5, 32'd9, 3'b001);
    drive(4'b0000, 32'd5, 32'd5, 3'b000);
    drive(4'b0011, 32'd5, 32'd5, 3'b000);
    drive(4'b1111, 32'd0, 32'd0, 3'b000);
    drive(4'b0001, 32'd7, 32'd7, 3'b010);

    for (int i = 0; i < 300; i++) begin
      bc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) bc = 4'b0001;
      d1 = $urandom;
      case ($urandom_range(0, 3))
        0:       d2 = d1;
        1:       d2 = ~d1;
        2:       d2 = d1 ^ 32'h8000_0000;
        default: d2 = $urandom;
      endcase
      drive(bc, d1, d2, 3'($urandom_range(0, 7)));
    end

    drive(4'b0010, 32'd1, 32'd2, 3'b000);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_is_branch_q",   32'(bus.is_branch_q),   32'd0);
    chk("midreset_branch_type_q", 32'(bus.branch_type_q), 32'd0);
    chk("midreset_comb_is_branch", 32'(bus.is_branch),    32'd1);
`ifdef BRANCH_CTRL_STATS_EN
    chk("midreset_taken_cnt", taken_cnt, 32'd0);
    chk("midreset_cond_cnt",  cond_cnt,  32'd0);
`endif
    @(posedge clk);
    #1;
    chk("held_reset_is_branch_q", 32'(bus.is_branch_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_is_branch_q", 32'(bus.is_branch_q), 32'd1);

    chk("scoreboard_drained", 32'(q_comb.size() + q_reg.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
